// File: rtl/serial_feeder_if.sv
// serial_feeder_if: handshake and serial-output bundle for serial_feeder.
//   din / din_valid / din_ready : parallel word handshake
//   ser_out / ser_en            : serial bit stream and downstream shift enable
//   busy / frame_done           : status
//   frames_sent                 : completed frame counter (wraps at 256)
// The master modport is the word producer and the output observer. The slave
// modport is the feeder itself.
interface serial_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_en;
    logic             busy;
    logic             frame_done;
    logic [7:0]       frames_sent;

    modport master (
        output din, din_valid,
        input  din_ready, ser_out, ser_en, busy, frame_done, frames_sent
    );

    modport slave (
        input  din, din_valid,
        output din_ready, ser_out, ser_en, busy, frame_done, frames_sent
    );
endinterface

// File: rtl/serial_feeder.sv
// serial_feeder: accepts a parallel word and emits it MSB first on ser_out.
// ser_en is high while bits are being shifted. A run of GAP_CYCLES idle
// cycles follows each frame.
//   CLK        : clock, rising edge
//   CLR        : asynchronous active-high clear
//   bus.slave  : din/din_valid/din_ready handshake, ser_out, ser_en, busy,
//                frame_done, frames_sent
// Optional macro SERIAL_FEEDER_PARITY_EN adds a trailing even-parity bit
// with ser_en held high.
module serial_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic           CLK,
    input  logic           CLR,
    serial_feeder_if.slave bus
);

`ifdef SERIAL_FEEDER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    localparam logic [3:0] LP_BLAST = 4'(WIDTH - 1);
    localparam logic [3:0] LP_GLAST = 4'(GAP_CYCLES - 1);

    state_t           r_state;
    // Holds only the bits not yet shown on ser_out. The MSB goes straight
    // to r_ser_out when the word is captured.
    logic [WIDTH-2:0] r_sreg;
    logic [3:0]       r_bcnt;
    logic [3:0]       r_gcnt;
    logic             r_ser_out;
    logic             r_ser_en;
    logic             r_busy;
    logic             r_frame_done;
    logic [7:0]       r_frames_sent;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             r_par;
`endif

    // The last ser_en-high cycle is in progress.
    logic w_frame_end;
`ifdef SERIAL_FEEDER_PARITY_EN
    assign w_frame_end = (r_state == PAR);
`else
    assign w_frame_end = (r_state == SHIFT) && (r_bcnt == 4'd0);
`endif

    assign bus.din_ready   = (r_state == IDLE) && !CLR;
    assign bus.ser_out     = r_ser_out;
    assign bus.ser_en      = r_ser_en;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.frames_sent = r_frames_sent;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state       <= IDLE;
            r_sreg        <= '0;
            r_bcnt        <= '0;
            r_gcnt        <= '0;
            r_ser_out     <= 1'b0;
            r_ser_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frames_sent <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
            r_par         <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.din_valid) begin
                        r_sreg    <= bus.din[WIDTH-2:0];
                        r_ser_out <= bus.din[WIDTH-1];
                        r_ser_en  <= 1'b1;
                        r_bcnt    <= LP_BLAST;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
                        r_par     <= ^bus.din;
`endif
                    end
                end
                SHIFT: begin
                    if (r_bcnt != 4'd0) begin
                        r_ser_out <= r_sreg[WIDTH-2];
                        r_sreg    <= r_sreg << 1;
                        r_bcnt    <= r_bcnt - 4'd1;
                    end
`ifdef SERIAL_FEEDER_PARITY_EN
                    else begin
                        // ser_en stays high for the parity bit.
                        r_ser_out <= r_par;
                        r_state   <= PAR;
                    end
`endif
                end
`ifdef SERIAL_FEEDER_PARITY_EN
                PAR: ;
`endif
                GAP: begin
                    if (r_gcnt == 4'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Common frame close-out. These assignments override the case
            // above for this edge.
            if (w_frame_end) begin
                r_ser_out     <= 1'b0;
                r_ser_en      <= 1'b0;
                r_frame_done  <= 1'b1;
                r_frames_sent <= r_frames_sent + 8'd1;
                if (GAP_CYCLES == 0) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= GAP;
                    r_gcnt  <= LP_GLAST;
                end
            end
        end
    end

endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width, legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles with ser_en low after each frame, legal range 0..15.
REQ-003 CLK  input  1: clock; all state updates occur on the rising edge.
REQ-004 CLR  input  1: reset, asynchronous, active-high.
REQ-005 din  input  WIDTH: parallel word to serialise.
REQ-006 din_valid  input  1: din is valid.
REQ-007 din_ready  output  1: block can accept a word this cycle.
REQ-008 ser_out  output  1: serial data bit, MSB first; feeds the downstream shift/rotate register data input.
REQ-009 ser_en  output  1: high means shift ser_out in; low means downstream rotates; feeds the downstream shift-enable input.
REQ-010 busy  output  1: high whenever the state is not IDLE.
REQ-011 frame_done  output  1: one-cycle pulse at the end of each frame.
REQ-012 frames_sent  output  8: count of completed frames, wraps modulo 256.

Function
REQ-013 The block SHALL implement the states IDLE, SHIFT, PAR (present only with PARITY_EN) and GAP.
REQ-014 din_ready SHALL equal (state==IDLE) and not CLR; a transfer occurs on a rising edge with din_valid=1 and din_ready=1.
REQ-015 On transfer, din SHALL be captured into the shift register, the bit counter loaded with WIDTH-1, and the state set to SHIFT; din is ignored at all other times.
REQ-016 In SHIFT: ser_en=1 and ser_out=shift register MSB; on each rising edge the register shifts left and the counter decrements; at counter==0 the next state is PAR if PARITY_EN is defined, else GAP.
REQ-017 The first data bit SHALL appear on ser_out in the cycle immediately after transfer; ser_en SHALL stay high for exactly WIDTH cycles (WIDTH+1 with PARITY_EN).
REQ-018 In GAP: ser_en=0 and ser_out=0 for exactly GAP_CYCLES cycles, then IDLE; if GAP_CYCLES=0, the block SHALL go from the last data/parity cycle straight to IDLE.
REQ-019 frame_done SHALL pulse high for one cycle, and frames_sent SHALL increment by one, in the cycle after the last ser_en-high cycle; frames_sent 255 wraps to 0.
REQ-020 In IDLE: ser_en=0 and ser_out=0.
REQ-021 ser_out, ser_en, busy, frame_done and frames_sent SHALL be registered and change only on the rising CLK edge, so they are stable across the downstream falling edge.
REQ-022 Back-to-back frames SHALL be spaced exactly WIDTH+GAP_CYCLES+1 cycles apart (+1 with PARITY_EN) when din_valid is held high.

Reset
REQ-023 While CLR=1: state=IDLE, shift register=0, counters=0, ser_out=0, ser_en=0, busy=0, frame_done=0, frames_sent=0, din_ready=0.
REQ-024 CLR asserted mid-frame SHALL abort the frame immediately with no frame_done pulse and no frames_sent increment.
REQ-025 The first transfer SHALL be possible on the first rising edge after CLR deasserts.

Configuration
REQ-026 Macro SERIAL_FEEDER_PARITY_EN: when defined, the PAR state SHALL follow SHIFT for one cycle with ser_en=1 and ser_out=even parity (XOR of all captured bits); when undefined, no PAR state or parity logic SHALL exist.

Verification (WIDTH=8, GAP_CYCLES=2 unless stated)
REQ-027 Apply CLR, then transfer 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 with ser_en=1 for 8 cycles, then ser_en=0 for 2 cycles; frame_done pulses once; frames_sent=1.
REQ-028 With PARITY_EN defined, transfer 8'h07 then 8'h03 -> 9th ser_en-high bit is 1, then 0.
REQ-029 Hold din_valid=1 with din 8'hFF then 8'h00 -> second transfer occurs exactly 11 cycles after the first; din changes while busy have no effect.
REQ-030 Assert CLR after 3 bits of 8'hF0 -> ser_en=0 and busy=0 immediately; no frame_done; frames_sent=0; a following 8'h3C is sent intact.
REQ-031 Send 256 frames -> frames_sent reads 255 after frame 255 and 0 after frame 256.
REQ-032 With GAP_CYCLES=0 and continuous 8'h81 -> ser_en low for exactly 1 cycle (the IDLE cycle) between frames.
